// File: rtl/bip_control_sequencer_pkg.sv
// Shared BIP I definitions: opcodes, datapath mux encodings, FSM states, control bundle.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bip_control_sequencer_pkg;

    localparam int OPC_W = 5;

    // Instruction set opcodes; everything above OP_SUBI executes as a NOP
    localparam logic [OPC_W-1:0] OP_HLT  = 5'b00000;
    localparam logic [OPC_W-1:0] OP_STO  = 5'b00001;
    localparam logic [OPC_W-1:0] OP_LD   = 5'b00010;
    localparam logic [OPC_W-1:0] OP_LDI  = 5'b00011;
    localparam logic [OPC_W-1:0] OP_ADD  = 5'b00100;
    localparam logic [OPC_W-1:0] OP_ADDI = 5'b00101;
    localparam logic [OPC_W-1:0] OP_SUB  = 5'b00110;
    localparam logic [OPC_W-1:0] OP_SUBI = 5'b00111;

    // Accumulator source select
    localparam logic [1:0] SELA_RAM = 2'b00;
    localparam logic [1:0] SELA_IMM = 2'b01;
    localparam logic [1:0] SELA_ALU = 2'b10;

    // ALU B operand select and ALU operation
    localparam logic SELB_RAM = 1'b0;
    localparam logic SELB_IMM = 1'b1;
    localparam logic ALU_ADD  = 1'b0;
    localparam logic ALU_SUB  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } state_e;

    // Control bundle driven towards the PC block and the datapath
    typedef struct packed {
        logic       wr_pc;
        logic       wr_acc;
        logic [1:0] sel_a;
        logic       sel_b;
        logic       op;
        logic       wr_ram;
        logic       rd_ram;
    } ctrl_t;

endpackage

// File: rtl/bip_instruction_decoder.sv
// Combinational opcode -> control bundle decode for the BIP I instruction set.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows the opcode input.
module bip_instruction_decoder
    import bip_control_sequencer_pkg::*;
(
    input  logic [OPC_W-1:0] opcode_i,
    output ctrl_t            ctrl_o
);

    // Every opcode except HLT advances the PC; datapath strobes per instruction
    always_comb begin
        ctrl_o       = '0;
        ctrl_o.wr_pc = (opcode_i != OP_HLT);
        case (opcode_i)
            OP_STO: begin
                ctrl_o.wr_ram = 1'b1;
            end
            OP_LD: begin
                ctrl_o.rd_ram = 1'b1;
                ctrl_o.wr_acc = 1'b1;
                ctrl_o.sel_a  = SELA_RAM;
            end
            OP_LDI: begin
                ctrl_o.wr_acc = 1'b1;
                ctrl_o.sel_a  = SELA_IMM;
            end
            OP_ADD: begin
                ctrl_o.rd_ram = 1'b1;
                ctrl_o.wr_acc = 1'b1;
                ctrl_o.sel_a  = SELA_ALU;
                ctrl_o.sel_b  = SELB_RAM;
                ctrl_o.op     = ALU_ADD;
            end
            OP_ADDI: begin
                ctrl_o.wr_acc = 1'b1;
                ctrl_o.sel_a  = SELA_ALU;
                ctrl_o.sel_b  = SELB_IMM;
                ctrl_o.op     = ALU_ADD;
            end
            OP_SUB: begin
                ctrl_o.rd_ram = 1'b1;
                ctrl_o.wr_acc = 1'b1;
                ctrl_o.sel_a  = SELA_ALU;
                ctrl_o.sel_b  = SELB_RAM;
                ctrl_o.op     = ALU_SUB;
            end
            OP_SUBI: begin
                ctrl_o.wr_acc = 1'b1;
                ctrl_o.sel_a  = SELA_ALU;
                ctrl_o.sel_b  = SELB_IMM;
                ctrl_o.op     = ALU_SUB;
            end
            default: begin
                // HLT and NOP range: no datapath activity
            end
        endcase
    end

endmodule

// File: rtl/bip_control_sequencer.sv
// BIP I control unit: fetch/execute FSM, instruction register, executed-cycle counter.
// Latency: one instruction per 2 cycles; control outputs are registered, valid during EXEC.
// Backpressure: none; the program memory must return data one cycle after a PC change.
module bip_control_sequencer
    import bip_control_sequencer_pkg::*;
#(
    parameter int OPCODE_BITS  = 5,
    parameter int OPERAND_BITS = 11,
    parameter int INSTR_BITS   = 16,
    parameter int CONT_BITS    = 32
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic                    i_enable,
    input  logic [INSTR_BITS-1:0]   i_instruction,
    output logic                    o_wrPC,
    output logic                    o_wrACC,
    output logic [1:0]              o_selA,
    output logic                    o_selB,
    output logic                    o_op,
    output logic                    o_wrRam,
    output logic                    o_rdRam,
    output logic [OPERAND_BITS-1:0] o_operand,
    output logic                    o_halted,
    output logic [CONT_BITS-1:0]    o_cycle_count
);

    state_e                 state_q;
    logic [INSTR_BITS-1:0]  ir_q;
    logic [CONT_BITS-1:0]   cnt_q;
    logic [CONT_BITS-1:0]   cnt_d;
    ctrl_t                  ctrl_q;
    logic                   halted_q;
    ctrl_t                  dec_ctrl;
    logic                   ir_is_hlt;

    // Decode the word being fetched so the EXEC-cycle outputs can be registered
    bip_instruction_decoder u_decoder (
        .opcode_i (i_instruction[INSTR_BITS-1 -: OPCODE_BITS]),
        .ctrl_o   (dec_ctrl)
    );

    assign ir_is_hlt = (ir_q[INSTR_BITS-1 -: OPCODE_BITS] == OP_HLT);

    // Saturating increment: the counter sticks at all-ones instead of wrapping
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_q != '1) begin
            cnt_d = cnt_q + CONT_BITS'(1);
        end
    end

    // Fetch/execute FSM with IR, counter and registered control outputs
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state_q  <= ST_IDLE;
            ir_q     <= '0;
            cnt_q    <= '0;
            ctrl_q   <= '0;
            halted_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_enable) begin
                        state_q <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    ir_q    <= i_instruction;
                    ctrl_q  <= dec_ctrl;
                    cnt_q   <= cnt_d;
                    state_q <= ST_EXEC;
                end
                ST_EXEC: begin
                    ctrl_q <= '0;
                    cnt_q  <= cnt_d;
                    if (ir_is_hlt) begin
                        state_q  <= ST_HALT;
                        halted_q <= 1'b1;
                    end else begin
                        state_q  <= ST_FETCH;
                    end
                end
                default: begin
                    // HALT: wait for reset
                end
            endcase
        end
    end

    assign o_wrPC        = ctrl_q.wr_pc;
    assign o_wrACC       = ctrl_q.wr_acc;
    assign o_selA        = ctrl_q.sel_a;
    assign o_selB        = ctrl_q.sel_b;
    assign o_op          = ctrl_q.op;
    assign o_wrRam       = ctrl_q.wr_ram;
    assign o_rdRam       = ctrl_q.rd_ram;
    assign o_operand     = ir_q[OPERAND_BITS-1:0];
    assign o_halted      = halted_q;
    assign o_cycle_count = cnt_q;

endmodule

// File: tb/tb_bip_control_sequencer.sv
// Bench for bip_control_sequencer: directed programs plus random programs vs. a cycle model.
// Latency: n/a.
// Backpressure: n/a.
module tb_bip_control_sequencer;

    logic        clk = 1'b0;
    logic        i_reset;
    logic        i_enable;
    logic [15:0] i_instruction;

    logic        wr_pc, wr_acc, sel_b, op, wr_ram, rd_ram, halted;
    logic [1:0]  sel_a;
    logic [10:0] operand;
    logic [31:0] count;

    logic        s_wr_pc, s_wr_acc, s_sel_b, s_op, s_wr_ram, s_rd_ram, s_halted;
    logic [1:0]  s_sel_a;
    logic [10:0] s_operand;
    logic [3:0]  s_count;

    logic [15:0] mem [0:2047];
    logic [10:0] pc;

    // reference model state
    int          m_run, m_exec, m_halt;
    logic [15:0] m_ir;
    longint      m_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign i_instruction = mem[pc];

    bip_control_sequencer dut (
        .i_clock(clk), .i_reset(i_reset), .i_enable(i_enable), .i_instruction(i_instruction),
        .o_wrPC(wr_pc), .o_wrACC(wr_acc), .o_selA(sel_a), .o_selB(sel_b), .o_op(op),
        .o_wrRam(wr_ram), .o_rdRam(rd_ram), .o_operand(operand), .o_halted(halted),
        .o_cycle_count(count)
    );

    bip_control_sequencer #(.CONT_BITS(4)) dut_s (
        .i_clock(clk), .i_reset(i_reset), .i_enable(i_enable), .i_instruction(i_instruction),
        .o_wrPC(s_wr_pc), .o_wrACC(s_wr_acc), .o_selA(s_sel_a), .o_selB(s_sel_b), .o_op(s_op),
        .o_wrRam(s_wr_ram), .o_rdRam(s_rd_ram), .o_operand(s_operand), .o_halted(s_halted),
        .o_cycle_count(s_count)
    );

    function automatic logic [7:0] ctrl_vec();
        return {wr_pc, wr_acc, sel_a, sel_b, op, wr_ram, rd_ram};
    endfunction

    function automatic logic [7:0] ctrl_vec_s();
        return {s_wr_pc, s_wr_acc, s_sel_a, s_sel_b, s_op, s_wr_ram, s_rd_ram};
    endfunction

    // Instruction table: {wrPC, wrACC, selA[1:0], selB, op, wrRam, rdRam}
    function automatic logic [7:0] op_table(input logic [4:0] opc);
        case (opc)
            5'd0:    return 8'b0_0_00_0_0_0_0;
            5'd1:    return 8'b1_0_00_0_0_1_0;
            5'd2:    return 8'b1_1_00_0_0_0_1;
            5'd3:    return 8'b1_1_01_0_0_0_0;
            5'd4:    return 8'b1_1_10_0_0_0_1;
            5'd5:    return 8'b1_1_10_1_0_0_0;
            5'd6:    return 8'b1_1_10_0_1_0_1;
            5'd7:    return 8'b1_1_10_1_1_0_0;
            default: return 8'b1_0_00_0_0_0_0;
        endcase
    endfunction

    function automatic logic [7:0] exp_ctrl();
        return (m_exec != 0) ? op_table(m_ir[15:11]) : 8'h00;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        longint sat4;
        sat4 = (m_cnt > 15) ? 15 : m_cnt;
        check("ctrl",     64'(ctrl_vec()),   64'(exp_ctrl()));
        check("ctrl_s",   64'(ctrl_vec_s()), 64'(exp_ctrl()));
        check("operand",  64'(operand),      64'(m_ir[10:0]));
        check("halted",   64'(halted),       64'(m_halt));
        check("halted_s", 64'(s_halted),     64'(m_halt));
        check("cnt32",    64'(count),        64'(m_cnt));
        check("cnt4",     64'(s_count),      64'(sat4));
    endtask

    // One clock: drive inputs, advance the model past the edge, compare at the falling edge
    task automatic tick(input logic en, input logic rst);
        logic [7:0]  cur;
        logic [15:0] instr;
        i_enable = en;
        i_reset  = rst;
        instr    = i_instruction;
        cur      = exp_ctrl();
        @(posedge clk);
        #1;
        if (!rst) begin
            m_run = 0; m_exec = 0; m_halt = 0; m_ir = '0; m_cnt = 0; pc = '0;
        end else begin
            if (cur[7]) pc = pc + 11'd1;
            if (m_halt != 0) begin
                // halted until reset
            end else if (m_run == 0) begin
                if (en) m_run = 1;
            end else if (m_exec == 0) begin
                m_ir = instr; m_exec = 1; m_cnt++;
            end else begin
                m_exec = 0; m_cnt++;
                if (m_ir[15:11] == 5'd0) begin
                    m_halt = 1; m_run = 0;
                end
            end
        end
        @(negedge clk);
        check_all();
    endtask

    initial begin
        int          first_h;
        logic [31:0] mask;
        i_reset = 1'b0; i_enable = 1'b0; pc = '0;
        m_run = 0; m_exec = 0; m_halt = 0; m_ir = '0; m_cnt = 0;
        for (int i = 0; i < 2048; i++) mem[i] = 16'h0000;

        // reset, then idle with enable low
        tick(0, 0); tick(0, 0);
        repeat (10) tick(0, 1);
        check("idle_ctrl", 64'(ctrl_vec()), 64'h0);
        check("idle_cnt",  64'(count), 64'h0);

        // LDI 5, ADDI 3, STO 7, HLT
        mem[0] = {5'd3, 11'd5}; mem[1] = {5'd5, 11'd3}; mem[2] = {5'd1, 11'd7}; mem[3] = 16'h0000;
        tick(1, 1);
        mask = 0; first_h = -1;
        for (int k = 1; k <= 10; k++) begin
            tick(0, 1);
            if (wr_pc) mask = mask | (32'd1 << (k + 1));
            if (halted && first_h < 0) first_h = k;
            if (k == 3) begin
                check("addi_ctrl", 64'(ctrl_vec()), 64'(8'b1_1_10_1_0_0_0));
                check("addi_opnd", 64'(operand), 64'd3);
            end
        end
        check("wrpc_edges", 64'(mask), 64'h54);
        check("halt_edge",  64'(first_h), 64'd8);
        check("halt_cnt",   64'(count), 64'd8);
        tick(1, 1); tick(1, 1);
        check("halt_en_cnt", 64'(count), 64'd8);
        check("halt_en_h",   64'(halted), 64'd1);

        // opcode 11111 behaves as NOP
        tick(0, 0);
        mem[0] = 16'hF8AB; mem[1] = 16'h0000;
        tick(1, 1); tick(0, 1);
        check("nop_ctrl", 64'(ctrl_vec()), 64'h80);
        tick(0, 1);
        check("nop_refetch", 64'(ctrl_vec()), 64'h00);
        repeat (3) tick(0, 1);

        // reset in the middle of SUB, then restart
        tick(0, 0);
        mem[0] = {5'd6, 11'd9}; mem[1] = {5'd3, 11'd1}; mem[2] = 16'h0000;
        tick(1, 1); tick(0, 1);
        check("sub_ctrl", 64'(ctrl_vec()), 64'(8'b1_1_10_0_1_0_1));
        tick(0, 0);
        check("rst_ctrl", 64'(ctrl_vec()), 64'h0);
        check("rst_cnt",  64'(count), 64'h0);
        check("rst_opnd", 64'(operand), 64'h0);
        tick(1, 1);
        repeat (6) tick(0, 1);
        check("restart_halt", 64'(halted), 64'd1);
        check("restart_cnt",  64'(count), 64'd6);

        // long NOP run: 4-bit counter saturates; enable noise while running
        tick(0, 0);
        for (int i = 0; i < 40; i++) mem[i] = 16'h4000 | 16'(i);
        mem[40] = 16'h0000;
        tick(1, 1);
        for (int k = 0; k < 20; k++) tick(1'($urandom_range(0, 1)), 1);
        check("sat4",  64'(s_count), 64'hF);
        check("sat32", 64'(count), 64'd20);

        // random programs, random enable and occasional reset
        for (int i = 0; i < 2048; i++) begin
            logic [4:0] opc;
            opc = ($urandom_range(0, 15) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            mem[i] = {opc, 11'($urandom)};
        end
        tick(0, 0);
        for (int k = 0; k < 600; k++) begin
            tick(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 60) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
